// File: rtl/uc_pkg.sv
// Shared types and constants for the unit-clause path: literal width,
// signed literal type and engine index type.
package uc_pkg;

  localparam int DATA_LEN_DEF = 512;
  localparam int LIT_W        = $clog2(DATA_LEN_DEF);
  localparam int NUM_ENG_DEF  = 4;
  localparam int ENG_IDX_W    = $clog2(NUM_ENG_DEF);

  typedef logic signed [LIT_W-1:0] lit_t;
  typedef logic [ENG_IDX_W-1:0]    eng_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr,
// scanning upward with wrap. Returns one-hot grant, its index and any.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] scan_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IW'((int'(ptr) + k) % N);
      if (!any && req[scan_idx]) begin
        any             = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

endmodule

// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: one literal slot per engine, round-robin push into
// the unit clause queue. Optional complement detection under UCA_CONFLICT_EN.
module uc_arbiter
  import uc_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int NUM_ENG  = NUM_ENG_DEF,
  localparam int LW = $clog2(DATA_LEN),
  localparam int IW = $clog2(NUM_ENG)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_ENG-1:0]                eng_valid,
  input  logic signed [NUM_ENG-1:0][LW-1:0] eng_lit,
  output logic [NUM_ENG-1:0]                eng_ready,
  input  logic                              q_full,
  output logic                              q_push,
  output logic signed [LW-1:0]              q_data,
  output logic                              conflict,
  output logic                              idle
);

  logic [NUM_ENG-1:0] hold_v;
  logic [LW-1:0]      hold_lit [NUM_ENG];
  logic [IW-1:0]      rr_ptr;

  logic [NUM_ENG-1:0] grant_raw;
  logic [NUM_ENG-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               req_any;
  logic               block;

  rr_arbiter #(.N(NUM_ENG)) u_rr (
    .req       (hold_v),
    .ptr       (rr_ptr),
    .grant     (grant_raw),
    .grant_idx (grant_idx),
    .any       (req_any)
  );

  assign q_push    = req_any && !q_full && !block;
  assign grant     = q_push ? grant_raw : '0;
  assign q_data    = q_push ? hold_lit[grant_idx] : '0;
  assign eng_ready = ~hold_v | grant;
  assign idle      = ~|hold_v;

  // A slot being drained this cycle may reload in the same edge; zero
  // literals are consumed but never occupy the slot.
  for (genvar i = 0; i < NUM_ENG; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_v[i]   <= 1'b0;
        hold_lit[i] <= '0;
      end else if (eng_valid[i] && eng_ready[i]) begin
        hold_v[i]   <= (eng_lit[i] != '0);
        hold_lit[i] <= eng_lit[i];
      end else if (grant[i]) begin
        hold_v[i]   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (q_push) begin
      rr_ptr <= (grant_idx == IW'(NUM_ENG - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

`ifdef UCA_CONFLICT_EN
  logic [NUM_ENG*NUM_ENG-1:0] pair_hit;
  logic                       conf_w;
  logic                       conflict_r;

  // x == -y tested as x + y == 0 in literal width
  for (genvar i = 0; i < NUM_ENG; i++) begin : g_ci
    for (genvar j = 0; j < NUM_ENG; j++) begin : g_cj
      if (j > i) begin : g_cmp
        assign pair_hit[i*NUM_ENG+j] = hold_v[i] && hold_v[j] &&
                                       (LW'(hold_lit[i] + hold_lit[j]) == '0);
      end else begin : g_none
        assign pair_hit[i*NUM_ENG+j] = 1'b0;
      end
    end
  end

  assign conf_w = |pair_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_r <= 1'b0;
    end else if (conf_w) begin
      conflict_r <= 1'b1;
    end
  end

  assign block    = conf_w || conflict_r;
  assign conflict = conflict_r;
`else
  assign block    = 1'b0;
  assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_uc_arbiter.sv
// Directed bench for uc_arbiter: push latency, round-robin order,
// backpressure, zero literals, conflict handling and mid-stream reset.
module tb_uc_arbiter;

  localparam int NE = 4;
  localparam int LW = 9;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NE-1:0]                eng_valid;
  logic signed [NE-1:0][LW-1:0] eng_lit;
  logic [NE-1:0]                eng_ready;
  logic                         q_full;
  logic                         q_push;
  logic signed [LW-1:0]         q_data;
  logic                         conflict;
  logic                         idle;

  int total = 0;
  int bad   = 0;

  uc_arbiter #(.DATA_LEN(512), .NUM_ENG(NE)) dut (
    .clk       (clk),
    .rst       (rst),
    .eng_valid (eng_valid),
    .eng_lit   (eng_lit),
    .eng_ready (eng_ready),
    .q_full    (q_full),
    .q_push    (q_push),
    .q_data    (q_data),
    .conflict  (conflict),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst       = 1'b1;
    eng_valid = '0;
    eng_lit   = '0;
    q_full    = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_ready", eng_ready, 4'hf);
    chk("rst_push", q_push, 0);
    chk("rst_data", q_data, 0);
    chk("rst_idle", idle, 1);
    chk("rst_conflict", conflict, 0);

    // single push, one-cycle latency
    eng_valid = 4'b0001;
    eng_lit[0] = 9'sd5;
    cyc();
    eng_valid = '0;
    chk("single_push", q_push, 1);
    chk("single_data", q_data, 5);
    chk("single_idle_busy", idle, 0);
    cyc();
    chk("single_after_push", q_push, 0);
    chk("single_after_idle", idle, 1);

    // fairness from rr_ptr = 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    eng_valid = 4'b1111;
    eng_lit[0] = 9'sd1;
    eng_lit[1] = 9'sd2;
    eng_lit[2] = 9'sd3;
    eng_lit[3] = 9'sd4;
    cyc();
    eng_valid = '0;
    chk("rr_ready0", eng_ready, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      chk("rr_push", q_push, 1);
      chk("rr_data", q_data, k + 1);
      cyc();
    end
    chk("rr_done_push", q_push, 0);
    chk("rr_done_idle", idle, 1);

    // backpressure with slots 0 and 3 loaded
    q_full = 1'b1;
    eng_valid = 4'b1001;
    eng_lit[0] = 9'sd11;
    eng_lit[3] = -9'sd12;
    cyc();
    eng_valid = '0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_push", q_push, 0);
      chk("bp_ready", eng_ready, 4'b0110);
      cyc();
    end
    q_full = 1'b0;
    #1;
    chk("bp_push_a", q_push, 1);
    chk("bp_data_a", q_data, 11);
    cyc();
    chk("bp_push_b", q_push, 1);
    chk("bp_data_b", q_data, -12);
    cyc();
    chk("bp_idle", idle, 1);

    // zero literal is swallowed
    eng_valid = 4'b0100;
    eng_lit[2] = '0;
    #1;
    chk("zero_ready", eng_ready, 4'hf);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("zero_push", q_push, 0);
      chk("zero_idle", idle, 1);
    end
    eng_valid = '0;
    cyc();

    // complementary pair held together
    eng_valid = 4'b0011;
    eng_lit[0] = 9'sd7;
    eng_lit[1] = -9'sd7;
    cyc();
    eng_valid = '0;
`ifdef UCA_CONFLICT_EN
    chk("cf_push0", q_push, 0);
    chk("cf_flag0", conflict, 0);
    chk("cf_idle0", idle, 0);
    cyc();
    chk("cf_flag1", conflict, 1);
    chk("cf_push1", q_push, 0);
    chk("cf_ready1", eng_ready, 4'b1100);
    cyc();
    chk("cf_sticky", conflict, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("cf_clear", conflict, 0);
    chk("cf_clear_idle", idle, 1);
`else
    chk("cf_push_pos", q_push, 1);
    chk("cf_data_pos", q_data, 7);
    chk("cf_flag_pos", conflict, 0);
    cyc();
    chk("cf_push_neg", q_push, 1);
    chk("cf_data_neg", q_data, -7);
    cyc();
    chk("cf_done_push", q_push, 0);
    chk("cf_done_flag", conflict, 0);
`endif

    // move rr_ptr to 2 so the reset is visible in grant order
    eng_valid = 4'b0010;
    eng_lit[1] = 9'sd9;
    cyc();
    eng_valid = '0;
    chk("ptr_move_data", q_data, 9);
    cyc();

    // reset while three slots are held
    q_full = 1'b1;
    eng_valid = 4'b0111;
    eng_lit[0] = 9'sd21;
    eng_lit[1] = 9'sd22;
    eng_lit[2] = 9'sd23;
    cyc();
    eng_valid = '0;
    chk("mid_loaded", idle, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    q_full = 1'b0;
    #1;
    chk("mid_idle", idle, 1);
    chk("mid_push", q_push, 0);
    chk("mid_data", q_data, 0);
    chk("mid_ready", eng_ready, 4'hf);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("mid_no_stale", q_push, 0);
    end
    eng_valid = 4'b1001;
    eng_lit[0] = 9'sd41;
    eng_lit[3] = 9'sd44;
    cyc();
    eng_valid = '0;
    chk("mid_ptr_first", q_data, 41);
    cyc();
    chk("mid_ptr_second", q_data, 44);
    cyc();

    // single engine streaming with grant-and-reload each cycle
    eng_valid = 4'b0001;
    eng_lit[0] = 9'sd30;
    cyc();
    eng_lit[0] = 9'sd31;
    chk("stream_ready", eng_ready, 4'hf);
    chk("stream_d0", q_data, 30);
    cyc();
    eng_lit[0] = 9'sd32;
    chk("stream_d1", q_data, 31);
    cyc();
    eng_valid = '0;
    chk("stream_d2", q_data, 32);
    chk("stream_push", q_push, 1);
    cyc();
    chk("stream_end_push", q_push, 0);
    chk("stream_end_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
